// File: rtl/lcd_status_reader.sv
// lcd_status_reader: timed read transactions (status or data) on an HD44780-style LCD bus.
// One shared down-counter times the SETUP, EN_HIGH and HOLD phases.
// Optional macro LCD_BUSY_POLL_EN: repeat status reads until BF=0 or POLL_MAX reads are issued.
module lcd_status_reader #(
    parameter int unsigned SETUP_CYC = 3,
    parameter int unsigned EN_CYC    = 25,
    parameter int unsigned HOLD_CYC  = 22,
    parameter int unsigned POLL_MAX  = 1000
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       req,
    input  logic       rd_rs,
    input  logic       poll,
    input  logic [7:0] LCD_DATA_I,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       bus_own,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       done,
    output logic       timeout
);

    localparam int unsigned MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StEnHigh, StHold, StDone} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_rs, w_rs_next;
    logic [7:0]         r_rd_data, w_rd_data_next;
    logic               r_busy_flag, w_busy_flag_next;
    logic [6:0]         r_addr, w_addr_next;
    logic               w_again;
    logic               w_timeout_set;

`ifdef LCD_BUSY_POLL_EN
    localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);
    logic              r_poll, w_poll_next;
    logic [PCNT_W-1:0] r_poll_cnt, w_poll_cnt_next;
    logic              r_timeout, w_timeout_next;

    // Loop back while the read just completed still reported BF=1 and reads remain.
    assign w_again       = r_poll && !r_rs && r_busy_flag && (r_poll_cnt < PCNT_W'(POLL_MAX));
    assign w_timeout_set = r_poll && !r_rs && r_busy_flag;
`else
    logic w_unused_poll;
    assign w_unused_poll = poll;
    assign w_again       = 1'b0;
    assign w_timeout_set = 1'b0;
`endif

    // State, counter and captured-data registers.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_rs        <= 1'b0;
            r_rd_data   <= 8'h00;
            r_busy_flag <= 1'b0;
            r_addr      <= 7'h00;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rs        <= w_rs_next;
            r_rd_data   <= w_rd_data_next;
            r_busy_flag <= w_busy_flag_next;
            r_addr      <= w_addr_next;
        end
    end

`ifdef LCD_BUSY_POLL_EN
    // Poll bookkeeping: latched poll request, reads issued, exhaustion flag.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            r_poll     <= 1'b0;
            r_poll_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_poll     <= w_poll_next;
            r_poll_cnt <= w_poll_cnt_next;
            r_timeout  <= w_timeout_next;
        end
    end
`endif

    // Next-state, counter reloads, data capture and bus outputs decoded from state.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_rs_next        = r_rs;
        w_rd_data_next   = r_rd_data;
        w_busy_flag_next = r_busy_flag;
        w_addr_next      = r_addr;
`ifdef LCD_BUSY_POLL_EN
        w_poll_next      = r_poll;
        w_poll_cnt_next  = r_poll_cnt;
        w_timeout_next   = r_timeout;
`endif
        LCD_RS  = 1'b0;
        LCD_RW  = 1'b0;
        LCD_EN  = 1'b0;
        bus_own = 1'b0;
        done    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (req) begin
                    w_state_next = StSetup;
                    w_cnt_next   = CNT_W'(SETUP_CYC - 1);
                    w_rs_next    = rd_rs;
`ifdef LCD_BUSY_POLL_EN
                    w_poll_next     = poll;
                    w_poll_cnt_next = '0;
                    w_timeout_next  = 1'b0;
`endif
                end
            end
            StSetup: begin
                LCD_RS  = r_rs;
                LCD_RW  = 1'b1;
                bus_own = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = StEnHigh;
                    w_cnt_next   = CNT_W'(EN_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StEnHigh: begin
                LCD_RS  = r_rs;
                LCD_RW  = 1'b1;
                LCD_EN  = 1'b1;
                bus_own = 1'b1;
                if (r_cnt == '0) begin
                    // Capture while EN is still high; EN drops next cycle.
                    w_rd_data_next = LCD_DATA_I;
                    if (!r_rs) begin
                        w_busy_flag_next = LCD_DATA_I[7];
                        w_addr_next      = LCD_DATA_I[6:0];
                    end
`ifdef LCD_BUSY_POLL_EN
                    w_poll_cnt_next = r_poll_cnt + PCNT_W'(1);
`endif
                    w_state_next = StHold;
                    w_cnt_next   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StHold: begin
                LCD_RS  = r_rs;
                LCD_RW  = 1'b1;
                bus_own = 1'b1;
                if (r_cnt == '0) begin
                    if (w_again) begin
                        w_state_next = StSetup;
                        w_cnt_next   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        w_state_next = StDone;
`ifdef LCD_BUSY_POLL_EN
                        w_timeout_next = w_timeout_set;
`endif
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign rd_data   = r_rd_data;
    assign busy_flag = r_busy_flag;
    assign addr      = r_addr;
`ifdef LCD_BUSY_POLL_EN
    assign timeout   = done && r_timeout;
`else
    assign timeout   = 1'b0 & w_timeout_set;
`endif

endmodule

// File: doc/lcd_status_reader.md
LCD_STATUS_READER -- requirements
Module: lcd_status_reader

Interface
REQ-001 Parameter SETUP_CYC, default 3, RS/RW setup cycles before EN rises (60 ns at 50 MHz).
REQ-002 Parameter EN_CYC, default 25, LCD_EN high-pulse cycles (500 ns).
REQ-003 Parameter HOLD_CYC, default 22, cycles after EN falls before the read completes (total 50 cycles = 1000 ns).
REQ-004 Parameter POLL_MAX, default 1000, maximum status reads per polled request.
REQ-005 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 req  in  1  start one read transaction; sampled only in IDLE.
REQ-008 rd_rs  in  1  0 = status read (BF + address counter), 1 = DDRAM/CGRAM data read; latched on accept.
REQ-009 poll  in  1  repeat status reads until BF=0; latched on accept; used only with LCD_BUSY_POLL_EN.
REQ-010 LCD_DATA_I  in  8  LCD DB[7:0] as seen from the pad.
REQ-011 LCD_RS  out  1  register select to panel.
REQ-012 LCD_RW  out  1  1 = read; high for the whole transaction.
REQ-013 LCD_EN  out  1  enable strobe.
REQ-014 bus_own  out  1  high while this block owns the LCD bus; the writer must tri-state LCD_DATA while high.
REQ-015 rd_data  out  8  byte captured from LCD_DATA_I.
REQ-016 busy_flag  out  1  rd_data[7] of the last status read.
REQ-017 addr  out  7  rd_data[6:0] of the last status read.
REQ-018 done  out  1  one-cycle pulse; read complete, outputs valid.
REQ-019 timeout  out  1  high with done when polling exhausted POLL_MAX reads.

Function
REQ-020 FSM states IDLE, SETUP, EN_HIGH, HOLD, DONE; one down-counter shared across timed states.
REQ-021 IDLE: req=1 at edge k -> SETUP from cycle k+1; rd_rs/poll latched; bus_own=1, LCD_RW=1, LCD_RS=latched rd_rs from k+1.
REQ-022 SETUP lasts SETUP_CYC cycles, LCD_EN=0; then EN_HIGH for EN_CYC cycles, LCD_EN=1.
REQ-023 LCD_DATA_I is sampled into rd_data on the last EN_HIGH cycle; LCD_EN falls the next cycle.
REQ-024 HOLD lasts HOLD_CYC cycles, LCD_EN=0, LCD_RW/RS/bus_own held.
REQ-025 DONE lasts one cycle: done=1, LCD_RW=0, LCD_RS=0, bus_own=0; next state IDLE; defaults give done at cycle k+51.
REQ-026 busy_flag/addr update only on status reads (rd_rs=0); data reads leave them unchanged.
REQ-027 req outside IDLE (including the DONE cycle) is ignored, not queued.
REQ-028 rd_data, busy_flag, addr hold their values between transactions.
REQ-029 LCD_EN never high while LCD_RW=0 or bus_own=0.

Reset
REQ-030 RST=1 at an edge forces IDLE, counter 0, poll count 0; LCD_EN, LCD_RW, LCD_RS, bus_own, done, timeout, busy_flag = 0; rd_data = 0x00; addr = 0.
REQ-031 RST mid-transaction aborts it: LCD_EN low on the next cycle, no done pulse, rd_data not updated after reset.
REQ-032 RST has priority over req in the same cycle.

Configuration
REQ-033 Macro LCD_BUSY_POLL_EN defined: request with poll=1 and rd_rs=0 loops HOLD->SETUP while sampled BF=1 and reads issued < POLL_MAX; ends in DONE when BF=0 (timeout=0) or after POLL_MAX reads with BF=1 (timeout=1); bus_own stays high across loops.
REQ-034 Macro undefined: poll ignored, exactly one read per request, timeout tied 0, no poll counter.

Verification
REQ-035 Status read, pad=0x2A, req at cycle 0 -> EN high cycles 4..28, done at 51, busy_flag=0, addr=0x2A, rd_data=0x2A.
REQ-036 Data read rd_rs=1, pad=0x41 -> LCD_RS=1 cycles 1..50, rd_data=0x41, busy_flag/addr unchanged from previous.
REQ-037 req pulsed at cycle 10 during a read -> ignored; exactly one done at 51.
REQ-038 RST at cycle 15 -> LCD_EN=0 at 16, bus_own=0, no done, outputs at reset values.
REQ-039 LCD_BUSY_POLL_EN, poll=1, pad=0x80 for 3 reads then 0x05 -> 4 EN pulses, done at cycle 201, busy_flag=0, addr=0x05, timeout=0.
REQ-040 LCD_BUSY_POLL_EN, POLL_MAX=4, pad stuck 0x80 -> 4 EN pulses, done with timeout=1, busy_flag=1.
